// File: rtl/shift_pkg.sv
// Shared definitions for the shift stage.
// Shift-type encodings as carried on the Sh port, and the datapath width,
// which doubles as the "shift by a full word" amount.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_type_e;

  localparam int unsigned SH_W    = 32;
  localparam logic [8:0]  SH_FULL = 9'd32;

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shifter with carry-out.
// Ports:
//   shin     value to shift
//   sh       shift type (LSL/LSR/ASR/ROR)
//   shamt    shift amount; only [4:0] used in immediate form
//   shimm    1 = immediate form, 0 = register form
//   carry_in current C flag
//   shout    shifted result
//   shcarry  shifter carry-out
module shift_core
  import shift_pkg::*;
(
  input  logic [SH_W-1:0] shin,
  input  logic [1:0]      sh,
  input  logic [7:0]      shamt,
  input  logic            shimm,
  input  logic            carry_in,
  output logic [SH_W-1:0] shout,
  output logic            shcarry
);

  logic [8:0]         amt;
  logic [5:0]         amt6;
  logic [4:0]         rot;
  logic [SH_W:0]      wide;
  logic signed [SH_W:0] swide;
  sh_type_e           op;

  always_comb begin
    op      = sh_type_e'(sh);
    shout   = shin;
    shcarry = carry_in;
    wide    = '0;
    swide   = '0;
    rot     = shamt[4:0];

    // Immediate #0 means #32 for the right shifts; LSL #0 stays a pass.
    if (shimm) begin
      amt = {4'b0, shamt[4:0]};
      if ((shamt[4:0] == 5'd0) && ((op == SH_LSR) || (op == SH_ASR)))
        amt = SH_FULL;
    end else begin
      amt = {1'b0, shamt};
    end
    // ASR saturates at 32, so clamping is harmless for it.
    amt6 = (amt >= SH_FULL) ? 6'd32 : amt[5:0];

    case (op)
      SH_LSL: begin
        if (amt == 9'd0) begin
          shout   = shin;
          shcarry = carry_in;
        end else if (amt <= SH_FULL) begin
          // Extra MSB catches the last bit shifted out.
          wide    = {1'b0, shin} << amt6;
          shout   = wide[SH_W-1:0];
          shcarry = wide[SH_W];
        end else begin
          shout   = '0;
          shcarry = 1'b0;
        end
      end
      SH_LSR: begin
        if (amt == 9'd0) begin
          shout   = shin;
          shcarry = carry_in;
        end else if (amt <= SH_FULL) begin
          // Extra LSB catches the last bit shifted out.
          wide    = {shin, 1'b0} >> amt6;
          shout   = wide[SH_W:1];
          shcarry = wide[0];
        end else begin
          shout   = '0;
          shcarry = 1'b0;
        end
      end
      SH_ASR: begin
        if (amt == 9'd0) begin
          shout   = shin;
          shcarry = carry_in;
        end else begin
          swide   = $signed({shin, 1'b0}) >>> amt6;
          shout   = swide[SH_W:1];
          shcarry = swide[0];
        end
      end
      default: begin
        if (shimm && (shamt[4:0] == 5'd0)) begin
          // RRX: rotate right by one through the carry flag.
          shout   = {carry_in, shin[SH_W-1:1]};
          shcarry = shin[0];
        end else if (shamt == 8'd0) begin
          shout   = shin;
          shcarry = carry_in;
        end else if (rot == 5'd0) begin
          shout   = shin;
          shcarry = shin[SH_W-1];
        end else begin
          shout   = (shin >> rot) | (shin << (6'd32 - {1'b0, rot}));
          shcarry = shout[SH_W-1];
        end
      end
    endcase
  end

endmodule

// File: rtl/shift_stage.sv
// Handshaked single-cycle shifter stage.
// Ports:
//   CLK, RESETn (async active-low), Flush (drops everything held)
//   InValid/InReady  upstream handshake; ShIn, Sh, ShAmt, ShImm, CarryIn, InTag
//   OutValid/OutReady downstream handshake; ShOut, ShCarry, OutTag
// Build option: define SHIFT_STAGE_SKID_EN for a 2-entry skid buffer with a
// registered InReady; otherwise a single output register whose InReady
// depends combinationally on OutReady.
module shift_stage
  import shift_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [SH_W-1:0]  ShIn,
  input  logic [1:0]       Sh,
  input  logic [7:0]       ShAmt,
  input  logic             ShImm,
  input  logic             CarryIn,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [SH_W-1:0]  ShOut,
  output logic             ShCarry,
  output logic [TAG_W-1:0] OutTag
);

  logic [SH_W-1:0]  res_p0;
  logic             carry_p0;
  logic             in_xfer;

  logic [SH_W-1:0]  res_p1;
  logic             carry_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             vld_p1;

  shift_core u_core (
    .shin     (ShIn),
    .sh       (Sh),
    .shamt    (ShAmt),
    .shimm    (ShImm),
    .carry_in (CarryIn),
    .shout    (res_p0),
    .shcarry  (carry_p0)
  );

  assign in_xfer  = InValid && InReady;
  assign OutValid = vld_p1;
  assign ShOut    = res_p1;
  assign ShCarry  = carry_p1;
  assign OutTag   = tag_p1;

`ifdef SHIFT_STAGE_SKID_EN
  logic [SH_W-1:0]  res_sk;
  logic             carry_sk;
  logic [TAG_W-1:0] tag_sk;
  logic             vld_sk;
  logic             rdy_q;

  assign InReady = rdy_q;

  // p0 -> p1 boundary; the skid entry only fills while p1 is stalled.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      carry_p1 <= 1'b0;
      tag_p1   <= '0;
      vld_sk   <= 1'b0;
      res_sk   <= '0;
      carry_sk <= 1'b0;
      tag_sk   <= '0;
      rdy_q    <= 1'b1;
    end else if (Flush) begin
      vld_p1 <= 1'b0;
      vld_sk <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (!vld_p1 || OutReady) begin
      if (vld_sk) begin
        res_p1   <= res_sk;
        carry_p1 <= carry_sk;
        tag_p1   <= tag_sk;
        vld_p1   <= 1'b1;
        vld_sk   <= in_xfer;
        rdy_q    <= !in_xfer;
        if (in_xfer) begin
          res_sk   <= res_p0;
          carry_sk <= carry_p0;
          tag_sk   <= InTag;
        end
      end else begin
        vld_p1 <= in_xfer;
        rdy_q  <= 1'b1;
        if (in_xfer) begin
          res_p1   <= res_p0;
          carry_p1 <= carry_p0;
          tag_p1   <= InTag;
        end
      end
    end else if (in_xfer) begin
      res_sk   <= res_p0;
      carry_sk <= carry_p0;
      tag_sk   <= InTag;
      vld_sk   <= 1'b1;
      rdy_q    <= 1'b0;
    end
  end
`else
  assign InReady = !vld_p1 || OutReady;

  // p0 -> p1 boundary
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      carry_p1 <= 1'b0;
      tag_p1   <= '0;
    end else if (Flush) begin
      vld_p1 <= 1'b0;
    end else if (in_xfer) begin
      vld_p1   <= 1'b1;
      res_p1   <= res_p0;
      carry_p1 <= carry_p0;
      tag_p1   <= InTag;
    end else if (OutReady) begin
      vld_p1 <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_shift_stage.sv
module tb_shift_stage;
  import shift_pkg::*;

  logic        CLK;
  logic        RESETn;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [31:0] ShIn;
  logic [1:0]  Sh;
  logic [7:0]  ShAmt;
  logic        ShImm;
  logic        CarryIn;
  logic [3:0]  InTag;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] ShOut;
  logic        ShCarry;
  logic [3:0]  OutTag;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic [3:0]  t;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;
  int   tests = 0;
  int   fails = 0;
  int   npop  = 0;

  shift_stage #(.TAG_W(4)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Flush    (Flush),
    .InValid  (InValid),
    .InReady  (InReady),
    .ShIn     (ShIn),
    .Sh       (Sh),
    .ShAmt    (ShAmt),
    .ShImm    (ShImm),
    .CarryIn  (CarryIn),
    .InTag    (InTag),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .ShOut    (ShOut),
    .ShCarry  (ShCarry),
    .OutTag   (OutTag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic drive(input sh_type_e t, input logic [7:0] amt, input logic imm,
                       input logic [31:0] v, input logic cin, input logic [3:0] tg,
                       input logic [31:0] er, input logic ec);
    InValid = 1'b1;
    Sh      = t;
    ShAmt   = amt;
    ShImm   = imm;
    ShIn    = v;
    CarryIn = cin;
    InTag   = tg;
    cur_exp = '{r: er, c: ec, t: tg};
  endtask

  // Pass-through operand: register LSL by 0 returns ShIn and CarryIn.
  task automatic drive_pass(input logic [31:0] v, input logic [3:0] tg);
    drive(SH_LSL, 8'd0, 1'b0, v, tg[0], tg, v, tg[0]);
  endtask

  task automatic tick(output bit acc);
    bit ret, fl;
    @(negedge CLK);
    acc = InValid && InReady;
    ret = OutValid && OutReady;
    fl  = Flush;
    @(posedge CLK);
    #1;
    if (fl) begin
      q.delete();
      acc = 1'b0;
    end else begin
      if (ret) begin
        void'(q.pop_front());
        npop++;
      end
      if (acc) q.push_back(cur_exp);
    end
  endtask

  task automatic check_out(input string nm);
    chk({nm, ".vld"}, 32'(OutValid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({nm, ".res"}, ShOut, q[0].r);
      chk({nm, ".c"},   32'(ShCarry), 32'(q[0].c));
      chk({nm, ".tag"}, 32'(OutTag), 32'(q[0].t));
    end
  endtask

  task automatic vec(input string nm, input sh_type_e t, input logic [7:0] amt,
                     input logic imm, input logic [31:0] v, input logic cin,
                     input logic [3:0] tg, input logic [31:0] er, input logic ec);
    bit acc;
    drive(t, amt, imm, v, cin, tg, er, ec);
    tick(acc);
    chk({nm, ".acc"}, 32'(acc), 32'd1);
    check_out(nm);
  endtask

  initial begin
    bit acc;
    int pops0;
    RESETn = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    ShIn = '0; Sh = '0; ShAmt = '0; ShImm = 1'b0; CarryIn = 1'b0; InTag = '0;
    cur_exp = '0;

    #12;
    chk("rst.vld", 32'(OutValid), 32'd0);
    chk("rst.res", ShOut, 32'd0);
    chk("rst.c",   32'(ShCarry), 32'd0);
    chk("rst.tag", 32'(OutTag), 32'd0);
    @(posedge CLK); #1;
    RESETn = 1'b1;
    chk("rst.inrdy", 32'(InReady), 32'd1);

    // Shift function, full throughput.
    vec("asr_reg4",   SH_ASR, 8'd4,    1'b0, 32'h8000_0010, 1'b0, 4'h1, 32'hF800_0001, 1'b0);
    vec("rrx",        SH_ROR, 8'd0,    1'b1, 32'h0000_0003, 1'b1, 4'h2, 32'h8000_0001, 1'b1);
    vec("lsl_reg32",  SH_LSL, 8'd32,   1'b0, 32'h0000_0001, 1'b0, 4'h3, 32'h0000_0000, 1'b1);
    vec("lsl_reg33",  SH_LSL, 8'd33,   1'b0, 32'h0000_0001, 1'b1, 4'h4, 32'h0000_0000, 1'b0);
    vec("lsl_imm0",   SH_LSL, 8'h20,   1'b1, 32'h1234_5678, 1'b1, 4'h5, 32'h1234_5678, 1'b1);
    vec("lsr_imm0",   SH_LSR, 8'd0,    1'b1, 32'h8000_0000, 1'b0, 4'h6, 32'h0000_0000, 1'b1);
    vec("asr_imm0",   SH_ASR, 8'd0,    1'b1, 32'h8000_0000, 1'b0, 4'h7, 32'hFFFF_FFFF, 1'b1);
    vec("lsr_reg4",   SH_LSR, 8'd4,    1'b0, 32'h0000_001F, 1'b0, 4'h8, 32'h0000_0001, 1'b1);
    vec("lsl_reg4",   SH_LSL, 8'd4,    1'b0, 32'hF000_0001, 1'b0, 4'h9, 32'h0000_0010, 1'b1);
    vec("ror_reg32",  SH_ROR, 8'h20,   1'b0, 32'h8000_0001, 1'b0, 4'hA, 32'h8000_0001, 1'b1);
    vec("ror_reg8",   SH_ROR, 8'd8,    1'b0, 32'h0000_00A5, 1'b0, 4'hB, 32'hA500_0000, 1'b1);
    vec("ror_imm4",   SH_ROR, 8'd4,    1'b1, 32'h0000_000F, 1'b0, 4'hC, 32'hF000_0000, 1'b1);
    vec("asr_reg0",   SH_ASR, 8'd0,    1'b0, 32'h8000_0000, 1'b0, 4'hD, 32'h8000_0000, 1'b0);
    vec("asr_reg200", SH_ASR, 8'd200,  1'b0, 32'h7FFF_FFFF, 1'b1, 4'hE, 32'h0000_0000, 1'b0);
    vec("lsr_reg40",  SH_LSR, 8'd40,   1'b0, 32'hFFFF_FFFF, 1'b1, 4'hF, 32'h0000_0000, 1'b0);
    InValid = 1'b0;
    tick(acc);
    check_out("drain");

    // Back-pressure: three stalled cycles with InValid held high.
    pops0 = npop;
    OutReady = 1'b0;
    drive_pass(32'hAAAA_0001, 4'h1);
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      if (acc) begin
        if (cur_exp.t == 4'h1) drive_pass(32'hBBBB_0002, 4'h2);
        else                   drive_pass(32'hCCCC_0003, 4'h3);
      end
      check_out($sformatf("stall%0d", i));
`ifdef SHIFT_STAGE_SKID_EN
      chk($sformatf("stall%0d.inrdy", i), 32'(InReady), 32'(i == 0));
`else
      chk($sformatf("stall%0d.inrdy", i), 32'(InReady), 32'd0);
`endif
    end
    OutReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(acc);
      if (acc && cur_exp.t == 4'h3) InValid = 1'b0;
      else if (acc && cur_exp.t == 4'h2) drive_pass(32'hCCCC_0003, 4'h3);
      check_out($sformatf("release%0d", i));
    end
    chk("bp.count", 32'(npop - pops0), 32'd3);

    // Flush with an operand held and a new one offered.
    OutReady = 1'b0;
    drive_pass(32'h1111_0001, 4'h5);
    tick(acc);
    check_out("fl.fill");
    Flush = 1'b1;
    drive_pass(32'hDEAD_BEEF, 4'h6);
    tick(acc);
    chk("fl.vld", 32'(OutValid), 32'd0);
    Flush = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(acc);
      check_out($sformatf("fl.after%0d", i));
    end

    // Asynchronous reset mid-burst.
    drive_pass(32'h5555_0001, 4'h7);
    tick(acc);
    drive_pass(32'h5555_0002, 4'h8);
    tick(acc);
    check_out("ar.busy");
    #3;
    RESETn = 1'b0;
    #1;
    q.delete();
    InValid = 1'b0;
    chk("ar.vld", 32'(OutValid), 32'd0);
    chk("ar.res", ShOut, 32'd0);
    @(posedge CLK); #2;
    RESETn = 1'b1;
    #1;
    chk("ar.inrdy", 32'(InReady), 32'd1);
    drive_pass(32'h7777_0001, 4'h9);
    tick(acc);
    check_out("ar.resume");
    InValid = 1'b0;
    tick(acc);
    check_out("ar.drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_stage.md
SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 SHALL have parameter TAG_W, default 4: width of the opaque sideband tag carried alongside each operand.
REQ-002 SHALL have port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RESETn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port Flush, input, 1: discards all held operands.
REQ-005 SHALL have port InValid, input, 1: upstream operand present.
REQ-006 SHALL have port InReady, output, 1: stage accepts an operand this cycle.
REQ-007 SHALL have port ShIn, input, 32: value to shift.
REQ-008 SHALL have port Sh, input, 2: shift type; 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-009 SHALL have port ShAmt, input, 8: shift amount.
REQ-010 SHALL have port ShImm, input, 1: 1 = immediate form (ShAmt[4:0] used); 0 = register form (full ShAmt[7:0] used).
REQ-011 SHALL have port CarryIn, input, 1: current C flag.
REQ-012 SHALL have port InTag, input, TAG_W: sideband passed through unchanged.
REQ-013 SHALL have port OutValid, output, 1: result present.
REQ-014 SHALL have port OutReady, input, 1: downstream accepts.
REQ-015 SHALL have ports ShOut (32), ShCarry (1) and OutTag (TAG_W), all outputs: result, shifter carry-out and tag.

Function
REQ-016 SHALL transfer an input on InValid&&InReady and an output on OutValid&&OutReady; latency is exactly 1 cycle from input transfer to OutValid when the stage is empty.
REQ-017 SHALL, for immediate form with amount 0, apply: LSL = pass ShIn, carry = CarryIn; LSR = treat as LSR #32; ASR = treat as ASR #32; ROR = RRX ({CarryIn, ShIn[31:1]}, carry = ShIn[0]).
REQ-018 SHALL, for register form with ShAmt==0, pass ShIn with carry = CarryIn for every type.
REQ-019 SHALL, for register LSL: amt 1..31 normal, carry = ShIn[32-amt]; amt 32 -> 0, carry ShIn[0]; amt >32 -> 0, carry 0.
REQ-020 SHALL, for register LSR: amt 1..31 normal, carry = ShIn[amt-1]; amt 32 -> 0, carry ShIn[31]; amt >32 -> 0, carry 0.
REQ-021 SHALL, for ASR with amt >=32 (either form), output 32 copies of ShIn[31] with carry ShIn[31].
REQ-022 SHALL, for register ROR with ShAmt[4:0]==0 and ShAmt!=0, pass ShIn with carry ShIn[31]; otherwise rotate by ShAmt[4:0] with carry = result[31].
REQ-023 SHALL hold ShOut/ShCarry/OutTag stable while OutValid && !OutReady.
REQ-024 SHALL, on Flush, clear all valid state at the next edge; Flush wins over a simultaneous input transfer, which is dropped; InReady may remain asserted during Flush.
REQ-025 SHALL never drop or duplicate an operand absent Flush; order is strictly FIFO.

Reset
REQ-026 SHALL, while RESETn is low, force OutValid=0, ShOut=0, ShCarry=0 and OutTag=0; InReady SHALL be 1 in the first cycle after release.
REQ-027 SHALL, on reset assertion mid-transfer, discard all in-flight operands.

Configuration
REQ-028 SHALL, with SHIFT_STAGE_SKID_EN defined, implement a 2-entry skid buffer: InReady is a registered signal, deasserted only when both entries are full, and full throughput is sustained under back-pressure.
REQ-029 SHALL, without SHIFT_STAGE_SKID_EN, implement a single output register with InReady = !OutValid || OutReady (combinational path from OutReady).

Structure
REQ-030 SHALL take the shift-type encodings (LSL/LSR/ASR/ROR) and the constant 32 from the shared package shift_pkg.
REQ-031 SHALL place all shift arithmetic in one combinational sub-module, shift_core, with shift_stage containing only handshake and storage logic.

Verification
REQ-032 SHALL check: register ASR, ShIn=0x80000010, ShAmt=4 -> ShOut 0xF8000001, ShCarry 0, one cycle after transfer.
REQ-033 SHALL check: immediate ROR #0, ShIn=0x00000003, CarryIn=1 -> ShOut 0x80000001, ShCarry 1.
REQ-034 SHALL check: register LSL, ShIn=0x00000001, ShAmt=32 -> ShOut 0, ShCarry 1; then ShAmt=33 -> ShOut 0, ShCarry 0.
REQ-035 SHALL check: OutReady held low for 3 cycles with InValid continuously high -> outputs stable, no loss; with SKID_EN, InReady drops only after 2 accepts.
REQ-036 SHALL check: Flush asserted together with InValid and OutValid=1 -> next cycle OutValid=0 and the flushed operand never appears.
REQ-037 SHALL check: RESETn pulsed low asynchronously mid-burst -> OutValid=0 immediately, InReady=1 after release.
